// File: rtl/mycustomled_pattern_engine_if.sv
// Register-file side bundle for the LED pattern engine: slave registers and strobes in,
// LED drive, step tick and status word out.
interface mycustomled_pattern_engine_if #(
  parameter int unsigned NUM_LEDS           = 8,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] pattern_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] duty_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rate_reg;
  logic [3:0]                    reg_wr_strobe;
  logic [NUM_LEDS-1:0]           led_out;
  logic                          tick_out;
  logic [C_S_AXI_DATA_WIDTH-1:0] status;

  modport master (
    output ctrl_reg, pattern_reg, duty_reg, rate_reg, reg_wr_strobe,
    input  led_out, tick_out, status
  );

  modport slave (
    input  ctrl_reg, pattern_reg, duty_reg, rate_reg, reg_wr_strobe,
    output led_out, tick_out, status
  );
endinterface

// File: rtl/mycustomled_pattern_engine.sv
// LED output stage behind the mycustomled register file: static/blink/rotate/bounce
// patterns stepped by a prescaler, PWM-dimmed, with a read-back status word.
module mycustomled_pattern_engine #(
  parameter int unsigned NUM_LEDS           = 8,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned PRESCALE_WIDTH     = 24
) (
  input logic ACLK,
  input logic ARESET,
  mycustomled_pattern_engine_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;

  localparam logic [7:0]  PWM_LAST     = 8'd254;
  localparam int unsigned STAT_FRAME_W = (NUM_LEDS > 16) ? 16 : NUM_LEDS;

  logic [1:0]                    state_q, state_d;
  logic [NUM_LEDS-1:0]           frame_q, frame_d;
  logic                          dir_q, dir_d;
  logic [7:0]                    step_q, step_d;
  logic [PRESCALE_WIDTH-1:0]     presc_q, presc_d;
  logic [1:0]                    mode_q, mode_d;
  logic [7:0]                    pwm_q, pwm_d;
  logic [NUM_LEDS-1:0]           led_q, led_d;
  logic                          tick_q, tick_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] status_q, status_d;

  logic                      enable;
  logic                      pwm_en;
  logic [1:0]                req_mode;
  logic [NUM_LEDS-1:0]       pattern;
  logic [PRESCALE_WIDTH-1:0] rate;
  logic                      pwm_on;
  logic                      step_tick;
  logic [NUM_LEDS-1:0]       stepped;
  logic                      stepped_dir;
  logic                      unused_bits;

  assign enable      = bus.ctrl_reg[0];
  assign req_mode    = bus.ctrl_reg[2:1];
  assign pwm_en      = bus.ctrl_reg[3];
  assign pattern     = bus.pattern_reg[NUM_LEDS-1:0];
  assign rate        = bus.rate_reg[PRESCALE_WIDTH-1:0];
  assign pwm_on      = (pwm_q < bus.duty_reg[7:0]);
  assign unused_bits = ^{bus.ctrl_reg, bus.pattern_reg, bus.duty_reg, bus.rate_reg,
                         bus.reg_wr_strobe[2], bus.reg_wr_strobe[0]};

  // Frame and direction the latched mode would produce on the next step.
  always_comb begin
    stepped     = frame_q;
    stepped_dir = dir_q;
    case (mode_q)
      MODE_STATIC: stepped = pattern;
      MODE_BLINK:  stepped = (frame_q == '0) ? pattern : '0;
      MODE_ROTATE: stepped = (frame_q << 1) | (frame_q >> (NUM_LEDS - 1));
      default: begin
        if (!dir_q) begin
          if (frame_q[NUM_LEDS-1]) begin
            stepped_dir = 1'b1;
            stepped     = frame_q >> 1;
          end else begin
            stepped = frame_q << 1;
          end
        end else begin
          if (frame_q[0]) begin
            stepped_dir = 1'b0;
            stepped     = frame_q << 1;
          end else begin
            stepped = frame_q >> 1;
          end
        end
      end
    endcase
  end

  // Sequencer, prescaler, PWM and output staging.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    dir_d     = dir_q;
    step_d    = step_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    step_tick = 1'b0;
    pwm_d     = (pwm_q == PWM_LAST) ? 8'd0 : pwm_q + 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        frame_d = '0;
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        frame_d = pattern;
        dir_d   = 1'b0;
        step_d  = 8'd0;
        presc_d = '0;
        mode_d  = req_mode;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Exits win over stepping; a disable blanks the frame at once.
        if (!enable) begin
          state_d = ST_IDLE;
          frame_d = '0;
        end else if (req_mode != mode_q || bus.reg_wr_strobe[1]) begin
          state_d = ST_LOAD;
        end else if (bus.reg_wr_strobe[3]) begin
          presc_d = '0;
        end else if (presc_q == rate) begin
          step_tick = 1'b1;
          presc_d   = '0;
          step_d    = step_q + 8'd1;
          frame_d   = stepped;
          dir_d     = stepped_dir;
        end else begin
          presc_d = presc_q + PRESCALE_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    led_d  = frame_d & {NUM_LEDS{pwm_on | ~pwm_en}};
    tick_d = step_tick;

    status_d                        = '0;
    status_d[0]                     = (state_q == ST_RUN);
    status_d[2:1]                   = mode_q;
    status_d[3]                     = dir_q;
    status_d[15:8]                  = step_q;
    status_d[16 +: STAT_FRAME_W]    = frame_q[STAT_FRAME_W-1:0];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      frame_q  <= '0;
      dir_q    <= 1'b0;
      step_q   <= 8'd0;
      presc_q  <= '0;
      mode_q   <= 2'd0;
      pwm_q    <= 8'd0;
      led_q    <= '0;
      tick_q   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      pwm_q    <= pwm_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
      status_q <= status_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.tick_out = tick_q;
  assign bus.status   = status_q;
endmodule

// File: tb/tb_mycustomled_pattern_engine.sv
// Bench for mycustomled_pattern_engine: hand-derived vector table, directed corner
// sequences, and randomized traffic against a behavioural model.
module tb_mycustomled_pattern_engine;
  logic aclk = 1'b0;
  logic areset;

  always #5 aclk = ~aclk;

  mycustomled_pattern_engine_if #(.NUM_LEDS(8), .C_S_AXI_DATA_WIDTH(32)) bus ();

  mycustomled_pattern_engine #(
    .NUM_LEDS(8), .C_S_AXI_DATA_WIDTH(32), .PRESCALE_WIDTH(24)
  ) dut (
    .ACLK(aclk),
    .ARESET(areset),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Stimulus for the next cycle.
  logic        t_rst;
  logic [31:0] t_ctrl, t_pat, t_duty, t_rate;
  logic [3:0]  t_strobe;

  // Behavioural model: phase 0 = off, 1 = loading, 2 = running.
  int unsigned m_phase, m_frame, m_dir, m_steps, m_cnt, m_mode, m_pwm;
  logic [31:0] m_led, m_tick, m_status;
  localparam int unsigned CNT_MOD = 32'h0100_0000;

  typedef struct {
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] pat;
    logic [3:0]  strobe;
    logic [7:0]  led;
    logic        tick;
    logic [31:0] status;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_bounce [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, req);
    else
      n_pass++;
  endtask

  task automatic advance_frame(input int unsigned pat);
    case (m_mode)
      0: m_frame = pat;
      1: m_frame = (m_frame == 0) ? pat : 0;
      2: m_frame = (m_frame * 2) % 256 + m_frame / 128;
      default: begin
        // Turn around when the light sits on the wall it is heading for.
        if (m_dir == 0 && m_frame >= 128) m_dir = 1;
        else if (m_dir == 1 && (m_frame % 2) == 1) m_dir = 0;
        m_frame = (m_dir == 0) ? (m_frame * 2) % 256 : m_frame / 2;
      end
    endcase
  endtask

  task automatic model_step();
    int unsigned pat, want_mode, rate;
    bit lit;
    if (t_rst) begin
      m_phase = 0; m_frame = 0; m_dir = 0; m_steps = 0; m_cnt = 0; m_mode = 0; m_pwm = 0;
      m_led = 0; m_tick = 0; m_status = 0;
      return;
    end
    m_status  = 32'((m_phase == 2) ? 1 : 0) + 32'(m_mode * 2) + 32'(m_dir * 8)
              + 32'(m_steps * 256) + 32'(m_frame * 65536);
    lit       = !t_ctrl[3] || (m_pwm < 32'(t_duty[7:0]));
    pat       = 32'(t_pat[7:0]);
    want_mode = 32'(t_ctrl[2:1]);
    rate      = 32'(t_rate[23:0]);
    m_tick    = 0;
    if (m_phase == 0) begin
      m_frame = 0;
      if (t_ctrl[0]) m_phase = 1;
    end else if (m_phase == 1) begin
      m_frame = pat; m_dir = 0; m_steps = 0; m_cnt = 0; m_mode = want_mode; m_phase = 2;
    end else if (!t_ctrl[0]) begin
      m_phase = 0; m_frame = 0;
    end else if (want_mode != m_mode || t_strobe[1]) begin
      m_phase = 1;
    end else if (t_strobe[3]) begin
      m_cnt = 0;
    end else if (m_cnt != rate) begin
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end else begin
      m_cnt   = 0;
      m_tick  = 1;
      m_steps = (m_steps + 1) % 256;
      advance_frame(pat);
    end
    m_led = lit ? 32'(m_frame) : 32'd0;
    m_pwm = (m_pwm + 1) % 255;
  endtask

  // One clock: drive stimulus, advance model, sample mid-cycle, optionally compare.
  task automatic run_cycle(input bit chk);
    areset            = t_rst;
    bus.ctrl_reg      = t_ctrl;
    bus.pattern_reg   = t_pat;
    bus.duty_reg      = t_duty;
    bus.rate_reg      = t_rate;
    bus.reg_wr_strobe = t_strobe;
    @(posedge aclk);
    model_step();
    @(negedge aclk);
    cyc++;
    if (chk) begin
      check("led_out", 32'(bus.led_out), m_led);
      check("tick_out", 32'(bus.tick_out), m_tick);
      check("status", bus.status, m_status);
    end
    t_strobe = 4'h0;
  endtask

  task automatic do_reset();
    t_rst = 1'b1; t_ctrl = 32'h0; t_strobe = 4'h0;
    run_cycle(1'b1);
    t_rst = 1'b0;
  endtask

  task automatic add_vec(input logic r, input logic [31:0] c, input logic [31:0] p,
                         input logic [3:0] s, input logic [7:0] l, input logic tk,
                         input logic [31:0] st);
    vec_t v;
    v.rst = r; v.ctrl = c; v.pat = p; v.strobe = s; v.led = l; v.tick = tk; v.status = st;
    vecs.push_back(v);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_on;
    t_rst = 1'b1; t_ctrl = 32'h0; t_pat = 32'h0; t_duty = 32'h0; t_rate = 32'h0; t_strobe = 4'h0;
    @(negedge aclk);

    // ROTATE 0x81 at rate 0, disable, BOUNCE restart, reset mid-run, disable with pattern write.
    add_vec(1, 32'h0, 32'h81, 4'h0, 8'h00, 0, 32'h0000_0000);
    add_vec(0, 32'h5, 32'h81, 4'h0, 8'h00, 0, 32'h0000_0000);
    add_vec(0, 32'h5, 32'h81, 4'h0, 8'h81, 0, 32'h0000_0000);
    add_vec(0, 32'h5, 32'h81, 4'h0, 8'h03, 1, 32'h0081_0005);
    add_vec(0, 32'h5, 32'h81, 4'h0, 8'h06, 1, 32'h0003_0105);
    add_vec(0, 32'h5, 32'h81, 4'h0, 8'h0C, 1, 32'h0006_0205);
    add_vec(0, 32'h5, 32'h81, 4'h0, 8'h18, 1, 32'h000C_0305);
    add_vec(0, 32'h0, 32'h81, 4'h0, 8'h00, 0, 32'h0018_0405);
    add_vec(0, 32'h7, 32'h40, 4'h0, 8'h00, 0, 32'h0000_0404);
    add_vec(0, 32'h7, 32'h40, 4'h0, 8'h40, 0, 32'h0000_0404);
    add_vec(0, 32'h7, 32'h40, 4'h0, 8'h80, 1, 32'h0040_0007);
    add_vec(0, 32'h7, 32'h40, 4'h0, 8'h40, 1, 32'h0080_0107);
    add_vec(1, 32'h7, 32'h40, 4'h0, 8'h00, 0, 32'h0000_0000);
    add_vec(0, 32'h7, 32'h40, 4'h0, 8'h00, 0, 32'h0000_0000);
    add_vec(0, 32'h7, 32'h40, 4'h0, 8'h40, 0, 32'h0000_0000);
    add_vec(0, 32'h7, 32'h40, 4'h0, 8'h80, 1, 32'h0040_0007);
    add_vec(0, 32'h0, 32'h99, 4'h2, 8'h00, 0, 32'h0080_0107);

    foreach (vecs[i]) begin
      t_rst = vecs[i].rst; t_ctrl = vecs[i].ctrl; t_pat = vecs[i].pat; t_strobe = vecs[i].strobe;
      run_cycle(1'b0);
      check("vec_led", 32'(bus.led_out), 32'(vecs[i].led));
      check("vec_tick", 32'(bus.tick_out), 32'(vecs[i].tick));
      check("vec_status", bus.status, vecs[i].status);
    end

    // BOUNCE 0x40 at rate 1: each frame held two cycles, reversing at both walls.
    exp_bounce = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h40, 8'h40, 8'h20, 8'h20, 8'h10, 8'h10,
                   8'h08, 8'h08, 8'h04, 8'h04, 8'h02, 8'h02, 8'h01, 8'h01, 8'h02, 8'h02};
    t_ctrl = 32'h0; do_reset();
    t_ctrl = 32'h7; t_pat = 32'h40; t_rate = 32'h1; t_duty = 32'h0;
    run_cycle(1'b1);
    for (int k = 0; k < 20; k++) begin
      run_cycle(1'b1);
      check("bounce_led", 32'(bus.led_out), 32'(exp_bounce[k]));
    end

    // Mode change together with a pattern write: one LOAD, new pattern shown.
    t_ctrl = 32'h5; t_pat = 32'h3C; t_strobe = 4'h2;
    run_cycle(1'b1);
    run_cycle(1'b1);
    check("simul_led", 32'(bus.led_out), 32'h3C);
    run_cycle(1'b1);
    check("simul_status", 32'(bus.status[2:0]), 32'h5);

    // ROTATE at rate 0: step count wraps after 256 ticks.
    t_ctrl = 32'h0; do_reset();
    t_ctrl = 32'h5; t_pat = 32'h81; t_rate = 32'h0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    for (int j = 0; j <= 256; j++) begin
      run_cycle(1'b1);
      if (j == 255) begin
        check("wrap_step255", 32'(bus.status[15:8]), 32'd255);
        check("wrap_led", 32'(bus.led_out), 32'h81);
      end
      if (j == 256) check("wrap_step0", 32'(bus.status[15:8]), 32'd0);
    end

    // BLINK with PWM dimming at duty 64 and rate 999.
    t_ctrl = 32'h0; do_reset();
    t_ctrl = 32'hB; t_pat = 32'hFF; t_duty = 32'd64; t_rate = 32'd999;
    run_cycle(1'b1);
    cnt_on = 0;
    for (int s = 1; s <= 255; s++) begin
      run_cycle(1'b1);
      if (bus.led_out == 8'hFF) cnt_on++;
    end
    check("blink_on_count", 32'(cnt_on), 32'd64);
    cnt_on = 0;
    for (int s = 256; s <= 1255; s++) begin
      run_cycle(1'b1);
      if (s == 1001) check("blink_tick", 32'(bus.tick_out), 32'd1);
      if (s >= 1001 && bus.led_out != 8'h00) cnt_on++;
    end
    check("blink_off_count", 32'(cnt_on), 32'd0);

    t_duty = 32'd0; t_strobe = 4'h2;
    run_cycle(1'b1);
    cnt_on = 0;
    for (int s = 0; s < 300; s++) begin
      run_cycle(1'b1);
      if (bus.led_out != 8'h00) cnt_on++;
    end
    check("duty0_count", 32'(cnt_on), 32'd0);

    t_duty = 32'd255; t_strobe = 4'h2;
    run_cycle(1'b1);
    cnt_on = 0;
    for (int s = 0; s < 300; s++) begin
      run_cycle(1'b1);
      if (bus.led_out == 8'hFF) cnt_on++;
    end
    check("duty255_count", 32'(cnt_on), 32'd300);

    // Randomized register traffic against the model.
    t_ctrl = 32'h0; t_rate = 32'h0; do_reset();
    for (int i = 0; i < 4000; i++) begin
      t_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) begin
        t_ctrl = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) t_ctrl[0] = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) begin
        t_pat = $urandom; t_strobe[1] = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) begin
        t_rate = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) t_strobe[3] = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) t_strobe[3] = 1'b1;
      if ($urandom_range(0, 79) == 0) t_duty = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0) t_strobe[0] = 1'b1;
      run_cycle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mycustomled_pattern_engine.md
Name: mycustomled_pattern_engine

Overview:
- LED output stage that sits directly downstream of the mycustomled AXI4-Lite slave register file.
- Consumes the four slave registers (control, pattern, duty, rate) and per-register write strobes.
- Produces the physical LED drive: static, blink, rotate and bounce patterns with PWM dimming.
- Returns a status word that the slave maps onto a read-only register.

Parameters:
- NUM_LEDS, 8: LED count; the frame width; 1..32.
- C_S_AXI_DATA_WIDTH, 32: register width.
- PRESCALE_WIDTH, 24: width of the step-rate prescaler; ≤ C_S_AXI_DATA_WIDTH.

Ports:
- ACLK  in  1  single clock.
- ARESET  in  1  synchronous, active-high reset.
- ctrl_reg  in  C_S_AXI_DATA_WIDTH  [0] enable; [2:1] mode (00 STATIC, 01 BLINK, 10 ROTATE, 11 BOUNCE); [3] pwm_en.
- pattern_reg  in  C_S_AXI_DATA_WIDTH  [NUM_LEDS-1:0] base pattern.
- duty_reg  in  C_S_AXI_DATA_WIDTH  [7:0] PWM duty.
- rate_reg  in  C_S_AXI_DATA_WIDTH  [PRESCALE_WIDTH-1:0] step period minus 1.
- reg_wr_strobe  in  4  one-cycle pulse; bit i set when slave register i is written.
- led_out  out  NUM_LEDS  registered LED drive.
- tick_out  out  1  one-cycle pulse per pattern step while running.
- status  out  C_S_AXI_DATA_WIDTH  [0] running; [2:1] active mode; [3] dir (1 = right); [15:8] step count; [16+NUM_LEDS-1:16] current frame (NUM_LEDS ≤ 16 for this field); other bits 0.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. ACLK is the clock and ARESET is the reset.
- Reset:
  - state = IDLE; frame, dir, step count, prescaler and PWM counter all 0.
  - led_out = 0, tick_out = 0, status = 0.
  - Reset asserted mid-operation aborts immediately; outputs are 0 on the cycle after ARESET is sampled high.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: frame = 0. Leave when ctrl_reg[0] = 1 → LOAD.
  - LOAD (one cycle): frame ← pattern_reg[NUM_LEDS-1:0]; dir ← 0 (left); step count ← 0; prescaler ← 0; latch mode ← ctrl_reg[2:1]. Next state is RUN.
  - RUN:
    - ctrl_reg[0] = 0 → IDLE.
    - ctrl_reg[2:1] ≠ latched mode → LOAD.
    - reg_wr_strobe[1] → LOAD (pattern restart).
    - Precedence when several hold: disable > mode change > pattern write.
- Prescaler (runs only in RUN):
  - Counts 0..rate_reg[PRESCALE_WIDTH-1:0].
  - step_tick fires on the cycle the count equals rate, then the count wraps to 0.
  - rate = 0 → a tick every cycle.
  - reg_wr_strobe[3] clears the count to 0 (no tick that cycle).
  - If the rate is lowered below the current count, the count wraps at 2^PRESCALE_WIDTH−1 (no tick until the wrap).
- Frame update on step_tick in RUN:
  - STATIC: frame ← pattern_reg (no change; pattern writes apply via LOAD).
  - BLINK: frame ← (frame == 0) ? pattern : 0.
  - ROTATE: rotate left by 1.
  - BOUNCE:
    - dir = 0: if frame[NUM_LEDS-1] = 1, set dir ← 1 and shift right by 1; otherwise shift left by 1.
    - dir = 1: if frame[0] = 1, set dir ← 0 and shift left by 1; otherwise shift right by 1.
    - Logical shifts, zero fill.
    - A frame with both end bits set reverses every tick.
  - frame = 0 holds 0 in every mode except BLINK.
- Step count: increments on each step_tick and wraps 255 → 0.
- tick_out equals step_tick, registered; it is high on the cycle after the count matches.
- PWM:
  - 8-bit counter runs freely 0..254 (period 255) in every state.
  - pwm_on = (pwm_cnt < duty_reg[7:0]).
  - duty 0 → always off; duty 255 → always on.
- Output:
  - led_out ← frame & {NUM_LEDS{pwm_on | ~ctrl_reg[3]}}, registered.
  - Latency with pwm_en = 0: ctrl_reg[0] rises in cycle N → LOAD in N+1 → led_out = pattern in N+2.
- Status: registered, one cycle behind the internal state.

Test Plan:
- Reset then enable: ctrl = 0x1, pattern = 0xA5, pwm off → led_out = 0xA5 two cycles after the enable; status[0] = 1; tick_out never asserts in STATIC with rate = 3 except as a 1-cycle pulse every 4 cycles.
- ROTATE: ctrl = 0x5, pattern = 0x81, rate = 0 → led_out sequence 0x81, 0x03, 0x06, 0x0C, one step per cycle; step count reaches 0x00 after 256 ticks (wrap).
- BOUNCE: ctrl = 0x7, pattern = 0x40, rate = 1 → 0x40, 0x80, 0x40, 0x20, …, 0x01, 0x02, each held 2 cycles; status[3] toggles at 0x80 and at 0x01.
- BLINK with PWM: ctrl = 0xB, pattern = 0xFF, duty = 64, rate = 999 → while on, led_out = 0xFF for 64 of every 255 cycles; toggles to 0 after 1000 cycles; duty 0 → led_out stays 0; duty 255 → no dimming.
- Simultaneous events: pulse reg_wr_strobe[1] on the same cycle ctrl_reg[0] drops → IDLE wins and led_out = 0; a mode change with a pattern write → a single LOAD with frame = the new pattern.
- Reset mid-run: ARESET asserted during BOUNCE → led_out, status and tick_out are 0 the next cycle; after release with enable still 1, LOAD then RUN restart from pattern_reg.
